// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter sharing one single-outstanding memory port
// between the instruction- and data-cache controllers.
// Optional memory timeout: define MEM_PORT_TIMEOUT_EN to add timeout_err and its counter.
module mem_port_arbiter #(
  parameter int ADDR_BITS      = 10,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  // Port 0: instruction cache controller
  input  logic                 rd0,
  input  logic                 wr0,
  input  logic [ADDR_BITS-1:0] addr0,
  input  logic [DATA_BITS-1:0] wdata0,
  // Port 1: data cache controller
  input  logic                 rd1,
  input  logic                 wr1,
  input  logic [ADDR_BITS-1:0] addr1,
  input  logic [DATA_BITS-1:0] wdata1,
  output logic                 ready0,
  output logic                 ready1,
  output logic [DATA_BITS-1:0] rdata,
  // Memory side
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic                 mem_ready,
  input  logic [DATA_BITS-1:0] mem_rdata,
`ifdef MEM_PORT_TIMEOUT_EN
  output logic                 timeout_err,
`endif
  output logic                 owner,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  state_e                state_q,     state_d;
  logic                  mem_rd_q,    mem_rd_d;
  logic                  mem_wr_q,    mem_wr_d;
  logic [ADDR_BITS-1:0]  mem_addr_q,  mem_addr_d;
  logic [DATA_BITS-1:0]  mem_wdata_q, mem_wdata_d;
  logic [DATA_BITS-1:0]  rdata_q,     rdata_d;
  logic                  ready0_q,    ready0_d;
  logic                  ready1_q,    ready1_d;
  logic                  busy_q,      busy_d;
  logic                  owner_q,     owner_d;
  logic                  last_q,      last_d;

`ifdef MEM_PORT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]      tmo_cnt_q,   tmo_cnt_d;
  logic                  tmo_err_q,   tmo_err_d;
`endif

  logic                  req0;
  logic                  req1;
  logic                  owner_req;
  logic                  grant_port;
  logic                  grant_rd;
  logic                  grant_wr;
  logic [ADDR_BITS-1:0]  grant_addr;
  logic [DATA_BITS-1:0]  grant_wdata;

  assign req0      = rd0 | wr0;
  assign req1      = rd1 | wr1;
  assign owner_req = owner_q ? req1 : req0;

  // Round-robin pick: on a tie the port not served last wins.
  always_comb begin
    if (req0 && req1) grant_port = ~last_q;
    else              grant_port = req1;
    grant_wr    = grant_port ? wr1    : wr0;
    grant_rd    = (grant_port ? rd1   : rd0) & ~grant_wr;
    grant_addr  = grant_port ? addr1  : addr0;
    grant_wdata = grant_port ? wdata1 : wdata0;
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    ready0_d    = 1'b0;
    ready1_d    = 1'b0;
    busy_d      = busy_q;
    owner_d     = owner_q;
    last_d      = last_q;
`ifdef MEM_PORT_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    tmo_err_d   = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          owner_d     = grant_port;
          busy_d      = 1'b1;
          mem_rd_d    = grant_rd;
          mem_wr_d    = grant_wr;
          mem_addr_d  = grant_addr;
          mem_wdata_d = grant_wdata;
`ifdef MEM_PORT_TIMEOUT_EN
          tmo_cnt_d   = '0;
`endif
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (mem_ready) begin
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          if (mem_rd_q) rdata_d = mem_rdata;
          ready0_d = ~owner_q;
          ready1_d = owner_q;
          state_d  = S_RELEASE;
        end
`ifdef MEM_PORT_TIMEOUT_EN
        else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Give up on the memory; rdata keeps its previous value.
          mem_rd_d  = 1'b0;
          mem_wr_d  = 1'b0;
          ready0_d  = ~owner_q;
          ready1_d  = owner_q;
          tmo_err_d = 1'b1;
          state_d   = S_RELEASE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
`endif
      end

      S_RELEASE: begin
        // Hold the grant until the owner withdraws its request.
        if (!owner_req) begin
          last_d  = owner_q;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      ready0_q    <= 1'b0;
      ready1_q    <= 1'b0;
      busy_q      <= 1'b0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
`ifdef MEM_PORT_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      tmo_err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge value of its peers.
      state_q     <= state_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      ready0_q    <= ready0_d;
      ready1_q    <= ready1_d;
      busy_q      <= busy_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
`ifdef MEM_PORT_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_err_q   <= tmo_err_d;
`endif
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;
  assign ready0    = ready0_q;
  assign ready1    = ready1_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
`ifdef MEM_PORT_TIMEOUT_EN
  assign timeout_err = tmo_err_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a per-cycle vector table plus
// hand-written sequences for round-robin, long waits, reset abort and timeout.
module tb_mem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ready0, ready1;
  logic [DW-1:0] rdata;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          owner, busy;
`ifdef MEM_PORT_TIMEOUT_EN
  logic          timeout_err;
`endif

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(
    .ADDR_BITS      (AW),
    .DATA_BITS      (DW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rd0       (rd0),
    .wr0       (wr0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .rd1       (rd1),
    .wr1       (wr1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .ready0    (ready0),
    .ready1    (ready1),
    .rdata     (rdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
`ifdef MEM_PORT_TIMEOUT_EN
    .timeout_err (timeout_err),
`endif
    .owner     (owner),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          rst;
    logic          rd0, wr0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          rd1, wr1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          mrdy;
    logic [DW-1:0] mrdata;
    logic          e_rd, e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_rdy0, e_rdy1;
    logic [DW-1:0] e_rdata;
    logic          e_busy, e_owner;
    string         name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    mem_ready = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    clear_inputs();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    // rst | rd0 wr0 addr0 wdata0 | rd1 wr1 addr1 wdata1 | mrdy mrdata || rd wr addr wdata rdy0 rdy1 rdata busy owner
    vecs.push_back('{1, 0,0,10'h000,8'h00, 0,0,10'h000,8'h00, 0,8'h00, 0,0,10'h000,8'h00, 0,0,8'h00,0,0, "reset"});
    vecs.push_back('{0, 1,0,10'h055,8'h00, 0,0,10'h000,8'h00, 0,8'h00, 1,0,10'h055,8'h00, 0,0,8'h00,1,0, "p0rd_grant"});
    vecs.push_back('{0, 1,0,10'h055,8'h00, 0,0,10'h000,8'h00, 0,8'h00, 1,0,10'h055,8'h00, 0,0,8'h00,1,0, "p0rd_wait"});
    vecs.push_back('{0, 1,0,10'h055,8'h00, 0,0,10'h000,8'h00, 1,8'hA5, 0,0,10'h055,8'h00, 1,0,8'hA5,1,0, "p0rd_ready"});
    vecs.push_back('{0, 0,0,10'h055,8'h00, 0,0,10'h000,8'h00, 1,8'h33, 0,0,10'h055,8'h00, 0,0,8'hA5,0,0, "p0rd_release"});
    vecs.push_back('{0, 0,0,10'h000,8'h00, 0,0,10'h000,8'h00, 1,8'hFF, 0,0,10'h055,8'h00, 0,0,8'hA5,0,0, "idle_ignore_mrdy"});
    vecs.push_back('{1, 0,0,10'h000,8'h00, 0,0,10'h000,8'h00, 0,8'h00, 0,0,10'h000,8'h00, 0,0,8'h00,0,0, "reset2"});
    vecs.push_back('{0, 1,0,10'h100,8'h11, 0,1,10'h3FF,8'h3C, 0,8'h00, 1,0,10'h100,8'h11, 0,0,8'h00,1,0, "tie_p0_first"});
    vecs.push_back('{0, 1,0,10'h100,8'h11, 0,1,10'h3FF,8'h3C, 1,8'h5A, 0,0,10'h100,8'h11, 1,0,8'h5A,1,0, "tie_p0_ready"});
    vecs.push_back('{0, 0,0,10'h100,8'h11, 0,1,10'h3FF,8'h3C, 0,8'h00, 0,0,10'h100,8'h11, 0,0,8'h5A,0,0, "tie_p0_release"});
    vecs.push_back('{0, 0,0,10'h100,8'h11, 0,1,10'h3FF,8'h3C, 0,8'h00, 0,1,10'h3FF,8'h3C, 0,0,8'h5A,1,1, "p1wr_grant"});
    vecs.push_back('{0, 0,0,10'h100,8'h11, 0,1,10'h3FF,8'h3C, 1,8'hEE, 0,0,10'h3FF,8'h3C, 0,1,8'h5A,1,1, "p1wr_ready"});
    vecs.push_back('{0, 0,0,10'h000,8'h00, 0,0,10'h3FF,8'h3C, 0,8'h00, 0,0,10'h3FF,8'h3C, 0,0,8'h5A,0,1, "p1wr_release"});
    vecs.push_back('{0, 1,1,10'h2AA,8'hC3, 0,0,10'h000,8'h00, 0,8'h00, 0,1,10'h2AA,8'hC3, 0,0,8'h5A,1,0, "rdwr_is_write"});
    vecs.push_back('{0, 1,1,10'h2AA,8'hC3, 0,0,10'h000,8'h00, 1,8'h99, 0,0,10'h2AA,8'hC3, 1,0,8'h5A,1,0, "rdwr_ready"});
    vecs.push_back('{0, 0,0,10'h000,8'h00, 0,0,10'h000,8'h00, 1,8'h77, 0,0,10'h2AA,8'hC3, 0,0,8'h5A,0,0, "rdwr_release"});

    foreach (vecs[i]) begin
      @(negedge clock);
      reset = vecs[i].rst;
      rd0 = vecs[i].rd0; wr0 = vecs[i].wr0; addr0 = vecs[i].addr0; wdata0 = vecs[i].wdata0;
      rd1 = vecs[i].rd1; wr1 = vecs[i].wr1; addr1 = vecs[i].addr1; wdata1 = vecs[i].wdata1;
      mem_ready = vecs[i].mrdy; mem_rdata = vecs[i].mrdata;
      tick();
      check({vecs[i].name, "_ctl"}, 32'({mem_rd, mem_wr, ready0, ready1, busy, owner}),
            32'({vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_rdy0, vecs[i].e_rdy1, vecs[i].e_busy, vecs[i].e_owner}));
      check({vecs[i].name, "_dat"}, 32'({mem_addr, mem_wdata, rdata}),
            32'({vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_rdata}));
    end

    // Both ports request continuously; each drops only for the cycle after its ready.
    begin
      logic owners[$];
      logic prev_busy;
      prev_busy = 1'b0;
      do_reset();
      mem_ready = 1'b1;
      addr0 = 10'h010;
      addr1 = 10'h020;
      for (int cyc = 0; cyc < 80 && owners.size() < 6; cyc++) begin
        @(negedge clock);
        rd0 = ~ready0;
        rd1 = ~ready1;
        tick();
        if (busy && !prev_busy) owners.push_back(owner);
        prev_busy = busy;
      end
      check("rr_grant_count", 32'(owners.size()), 32'd6);
      foreach (owners[i]) check($sformatf("rr_owner_%0d", i), 32'(owners[i]), 32'(i % 2));
    end

    // Port 1 write with a slow memory, its address wiggling, and a late release.
    do_reset();
    wr1 = 1'b1; addr1 = 10'h123; wdata1 = 8'h77;
    tick();
    check("slow_grant", 32'({mem_wr, mem_rd, owner, busy, mem_addr, mem_wdata}), 32'({4'b1011, 10'h123, 8'h77}));
    @(negedge clock);
    addr1 = 10'h000; wdata1 = 8'h00; rd1 = 1'b1;
    rd0 = 1'b1; addr0 = 10'h0AB;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("slow_hold_%0d", i), 32'({mem_wr, mem_rd, ready1, mem_addr, mem_wdata}),
            32'({3'b100, 10'h123, 8'h77}));
    end
    @(negedge clock);
    mem_ready = 1'b1;
    tick();
    check("slow_ready", 32'({ready1, ready0, mem_wr, busy}), 32'b1001);
    @(negedge clock);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("slow_linger_%0d", i), 32'({busy, ready1, mem_rd, owner}), 32'b1001);
    end
    @(negedge clock);
    wr1 = 1'b0; rd1 = 1'b0;
    tick();
    check("slow_idle", 32'(busy), 32'd0);
    tick();
    check("pending_p0_grant", 32'({owner, busy, mem_rd, mem_addr}), 32'({3'b011, 10'h0AB}));
    @(negedge clock);
    mem_ready = 1'b1; mem_rdata = 8'hC8;
    tick();
    check("pending_p0_ready", 32'({ready0, rdata}), 32'({1'b1, 8'hC8}));
    @(negedge clock);
    clear_inputs();
    tick();

    // Reset asserted mid-ISSUE aborts with no ready pulse.
    do_reset();
    rd0 = 1'b1; addr0 = 10'h0F0;
    tick();
    check("abort_pre", 32'({mem_rd, busy}), 32'b11);
    #2 reset = 1'b1;
    #1;
    check("abort_async", 32'({mem_rd, mem_wr, busy, ready0, ready1}), 32'd0);
    @(negedge clock);
    mem_ready = 1'b1; rd0 = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("abort_quiet_%0d", i), 32'({ready0, ready1, busy}), 32'd0);
    end
    @(negedge clock);
    mem_ready = 1'b0; rd0 = 1'b1; rd1 = 1'b1;
    tick();
    check("post_reset_p0_wins", 32'({busy, owner}), 32'b10);
    @(negedge clock);
    clear_inputs();
    mem_ready = 1'b1;
    tick();
    tick();

`ifdef MEM_PORT_TIMEOUT_EN
    // Memory never answers: give up four cycles after entering ISSUE.
    do_reset();
    rd0 = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("tmo_wait_%0d", i), 32'({timeout_err, ready0, mem_rd}), 32'b001);
    end
    tick();
    check("tmo_fire", 32'({timeout_err, ready0, mem_rd, rdata}), 32'({3'b110, 8'h00}));
    @(negedge clock);
    rd0 = 1'b0;
    tick();
    check("tmo_release", 32'({timeout_err, ready0, busy}), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
